// File: rtl/tx_mem_pkg.sv
// Shared types and constants for the TX memory stream reader.
// The FIFO and in-flight credit sizing below are derived from these constants.
package tx_mem_pkg;

    localparam int FIFO_DEPTH    = 4;
    localparam int READ_LATENCY  = 1;
    localparam int STREAM_DATA_W = 32;
    localparam int FIFO_PTR_W    = $clog2(FIFO_DEPTH);
    localparam int FIFO_COUNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [STREAM_DATA_W-1:0] data;
        logic                     sop;
        logic                     eop;
    } stream_word_t;

endpackage

// File: rtl/tx_mem_stream_fifo.sv
// Small show-ahead FIFO holding tagged stream words between the memory and the sink.
// The head word is visible on o_word whenever o_valid is high.
module tx_mem_stream_fifo
    import tx_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_push,
    input  stream_word_t            i_word,
    input  logic                    i_pop,
    output stream_word_t            o_word,
    output logic                    o_valid,
    output logic [FIFO_COUNT_W-1:0] o_count
);

    stream_word_t            r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0]   r_wrPtr;
    logic [FIFO_PTR_W-1:0]   r_rdPtr;
    logic [FIFO_COUNT_W-1:0] r_count;

    logic w_full;
    logic w_doPush;
    logic w_doPop;

    assign w_full   = (r_count == FIFO_COUNT_W'(FIFO_DEPTH));
    assign w_doPop  = i_pop && (r_count != '0);
    assign w_doPush = i_push && (!w_full || w_doPop);

    // Storage carries no reset; only the pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + FIFO_PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + FIFO_PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + FIFO_COUNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_word  = r_mem[r_rdPtr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/tx_mem_stream_reader.sv
// Avalon-MM read master that streams a programmed window of TX memory out as Avalon-ST,
// optionally looping, with reads throttled so the FIFO can never overflow.
module tx_mem_stream_reader
    import tx_mem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = STREAM_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic                loop_en,
    input  logic                stop,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata,
    output logic [DATA_W-1:0]   src_data,
    output logic                src_valid,
    input  logic                src_ready,
    output logic                src_sop,
    output logic                src_eop
);

    localparam int IDX_W = ADDR_W + 1;

    state_t                  r_state;
    state_t                  w_nextState;
    logic [ADDR_W-1:0]       r_base;
    logic [IDX_W-1:0]        r_length;
    logic                    r_loop;
    logic [IDX_W-1:0]        r_idx;
    logic [READ_LATENCY-1:0] r_inflight;
    logic [READ_LATENCY-1:0] r_sopPipe;
    logic [READ_LATENCY-1:0] r_eopPipe;
    logic                    r_zeroDone;

    logic                    w_credit;
    logic                    w_issue;
    logic                    w_lastIdx;
    logic                    w_drainDone;
    logic                    w_startRun;
    stream_word_t            w_pushWord;
    stream_word_t            w_headWord;
    logic                    w_fifoValid;
    logic [FIFO_COUNT_W-1:0] w_fifoCount;

    // Words already queued plus words still on their way from memory must fit in the FIFO.
    assign w_credit    = (4'(w_fifoCount) + 4'($countones(r_inflight))) < 4'(FIFO_DEPTH);
    assign w_issue     = (r_state == RUN) && !stop && w_credit;
    assign w_lastIdx   = (r_idx == (r_length - IDX_W'(1)));
    assign w_drainDone = (r_state == DRAIN) && (r_inflight == '0) && !w_fifoValid;
    assign w_startRun  = (r_state == IDLE) && start && (length != '0);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_startRun) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    w_nextState = DRAIN;
                end else if (w_issue && w_lastIdx && !r_loop) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drainDone) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_base     <= '0;
            r_length   <= '0;
            r_loop     <= 1'b0;
            r_idx      <= '0;
            r_inflight <= '0;
            r_sopPipe  <= '0;
            r_eopPipe  <= '0;
            r_zeroDone <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_zeroDone <= (r_state == IDLE) && start && (length == '0);
            // Tags are decided at issue time and travel alongside the read through the latency pipe.
            r_inflight <= READ_LATENCY'({r_inflight, w_issue});
            r_sopPipe  <= READ_LATENCY'({r_sopPipe, w_issue && (r_idx == '0)});
            r_eopPipe  <= READ_LATENCY'({r_eopPipe, w_issue && w_lastIdx});
            if (w_startRun) begin
                r_base   <= base_addr;
                r_length <= length;
                r_loop   <= loop_en;
                r_idx    <= '0;
            end else if (w_issue) begin
                r_idx <= w_lastIdx ? '0 : r_idx + IDX_W'(1);
            end
        end
    end

    always_comb begin
        w_pushWord      = '0;
        w_pushWord.data = avm_readdata;
        w_pushWord.sop  = r_sopPipe[READ_LATENCY-1];
        w_pushWord.eop  = r_eopPipe[READ_LATENCY-1];
    end

    tx_mem_stream_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (r_inflight[READ_LATENCY-1]),
        .i_word  (w_pushWord),
        .i_pop   (src_ready),
        .o_word  (w_headWord),
        .o_valid (w_fifoValid),
        .o_count (w_fifoCount)
    );

    assign busy           = (r_state != IDLE);
    assign done           = r_zeroDone || w_drainDone;
    assign avm_address    = r_base + r_idx[ADDR_W-1:0];
    assign avm_chipselect = w_issue;
    assign avm_write      = 1'b0;
    assign avm_byteenable = '1;
    assign avm_clken      = 1'b1;

    // Stream fields are forced to zero when nothing is presented so stale FIFO contents never leak.
    assign src_valid = w_fifoValid;
    assign src_data  = w_fifoValid ? w_headWord.data : '0;
    assign src_sop   = w_fifoValid && w_headWord.sop;
    assign src_eop   = w_fifoValid && w_headWord.eop;

endmodule

// File: tb/tb_tx_mem_stream_reader.sv
// Directed bench for tx_mem_stream_reader: a 1-cycle-latency memory model feeds the DUT,
// each scenario task logs reads, accepted words and done pulses per cycle and checks them.
module tb_tx_mem_stream_reader;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                start = 1'b0;
   logic [ADDR_W-1:0]   base_addr = '0;
   logic [ADDR_W:0]     length = '0;
   logic                loop_en = 1'b0;
   logic                stop = 1'b0;
   logic                busy;
   logic                done;
   logic [ADDR_W-1:0]   avm_address;
   logic                avm_chipselect;
   logic                avm_write;
   logic [DATA_W/8-1:0] avm_byteenable;
   logic                avm_clken;
   logic [DATA_W-1:0]   avm_readdata = '0;
   logic [DATA_W-1:0]   src_data;
   logic                src_valid;
   logic                src_ready = 1'b0;
   logic                src_sop;
   logic                src_eop;

   int checks = 0;
   int errors = 0;
   int cycleNum = 0;
   int busyCount = 0;
   logic prevStall = 1'b0;
   logic [DATA_W-1:0] prevData = '0;

   logic [DATA_W-1:0] mem [1024];

   int          csCycle[$];
   logic [9:0]  csAddr[$];
   logic [31:0] outData[$];
   logic        outSop[$];
   logic        outEop[$];
   int          outCycle[$];
   int          doneCycle[$];

   tx_mem_stream_reader dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .loop_en        (loop_en),
      .stop           (stop),
      .busy           (busy),
      .done           (done),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write      (avm_write),
      .avm_byteenable (avm_byteenable),
      .avm_clken      (avm_clken),
      .avm_readdata   (avm_readdata),
      .src_data       (src_data),
      .src_valid      (src_valid),
      .src_ready      (src_ready),
      .src_sop        (src_sop),
      .src_eop        (src_eop)
   );

   // Clock and a memory model with fixed one-cycle read latency
   always #5 clk = ~clk;

   always @(posedge clk) begin
      avm_readdata <= avm_chipselect ? mem[avm_address] : 32'hDEAD_BEEF;
   end

   task automatic clearLogs();
      csCycle.delete(); csAddr.delete(); outData.delete(); outSop.delete();
      outEop.delete(); outCycle.delete(); doneCycle.delete();
      cycleNum = 0;
      busyCount = 0;
      prevStall = 1'b0;
   endtask

   // Samples the current cycle (inputs already applied), then advances to the next negedge
   task automatic tick();
      #1;
      if (prevStall) begin
         checks++;
         if (src_valid !== 1'b1 || src_data !== prevData) begin
            errors++;
            $display("[TB] FAIL hold_stable cyc %0d: got valid=%b data=%h, want valid=1 data=%h",
                     cycleNum, src_valid, src_data, prevData);
         end
      end
      prevStall = src_valid && !src_ready;
      prevData  = src_data;
      if (avm_chipselect) begin
         csAddr.push_back(avm_address);
         csCycle.push_back(cycleNum);
      end
      if (src_valid && src_ready) begin
         outData.push_back(src_data);
         outSop.push_back(src_sop);
         outEop.push_back(src_eop);
         outCycle.push_back(cycleNum);
      end
      if (done) doneCycle.push_back(cycleNum);
      if (busy) busyCount++;
      @(negedge clk);
      cycleNum++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      #1;
      checks++;
      if ({busy, done, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
           src_valid, src_data, src_sop, src_eop} !==
          {1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_values: got busy=%b done=%b addr=%0d cs=%b wr=%b be=%h clken=%b valid=%b data=%h sop=%b eop=%b, want all 0 except be=f clken=1",
                  busy, done, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
                  src_valid, src_data, src_sop, src_eop);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      clearLogs();
      base_addr = 10'd0; length = 11'd4; loop_en = 1'b0; src_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      checks++;
      if (csAddr.size() != 4) begin
         errors++;
         $display("[TB] FAIL basic_reads: got %0d reads, want 4", csAddr.size());
      end
      for (int i = 0; i < 4 && i < csAddr.size(); i++) begin
         checks++;
         if (csAddr[i] !== 10'(i) || csCycle[i] != i + 1) begin
            errors++;
            $display("[TB] FAIL basic_read%0d: got addr=%0d cyc=%0d, want addr=%0d cyc=%0d",
                     i, csAddr[i], csCycle[i], i, i + 1);
         end
      end
      checks++;
      if (outData.size() != 4) begin
         errors++;
         $display("[TB] FAIL basic_words: got %0d words, want 4", outData.size());
      end
      for (int i = 0; i < 4 && i < outData.size(); i++) begin
         checks++;
         if (outData[i] !== 32'hA500_0000 + 32'(i) || outSop[i] !== (i == 0) ||
             outEop[i] !== (i == 3) || outCycle[i] != i + 3) begin
            errors++;
            $display("[TB] FAIL basic_word%0d: got data=%h sop=%b eop=%b cyc=%0d, want data=%h sop=%b eop=%b cyc=%0d",
                     i, outData[i], outSop[i], outEop[i], outCycle[i],
                     32'hA500_0000 + 32'(i), (i == 0), (i == 3), i + 3);
         end
      end
      checks++;
      if (doneCycle.size() != 1 || doneCycle[0] != 7) begin
         errors++;
         $display("[TB] FAIL basic_done: got %0d pulses first cyc=%0d, want 1 pulse at cyc 7",
                  doneCycle.size(), (doneCycle.size() > 0) ? doneCycle[0] : -1);
      end
   endtask

   task automatic test_wrap();
      logic [9:0]  expAddr [4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
      logic [31:0] expData [4] = '{32'hA500_03FE, 32'hA500_03FF, 32'hA500_0000, 32'hA500_0001};
      clearLogs();
      base_addr = 10'd1022; length = 11'd4; loop_en = 1'b0; src_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (11) tick();
      checks++;
      if (csAddr.size() != 4 || outData.size() != 4) begin
         errors++;
         $display("[TB] FAIL wrap_counts: got reads=%0d words=%0d, want 4 and 4",
                  csAddr.size(), outData.size());
      end
      for (int i = 0; i < 4 && i < csAddr.size() && i < outData.size(); i++) begin
         checks++;
         if (csAddr[i] !== expAddr[i] || outData[i] !== expData[i]) begin
            errors++;
            $display("[TB] FAIL wrap%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                     i, csAddr[i], outData[i], expAddr[i], expData[i]);
         end
      end
      checks++;
      if (doneCycle.size() != 1) begin
         errors++;
         $display("[TB] FAIL wrap_done: got %0d pulses, want 1", doneCycle.size());
      end
   endtask

   task automatic test_backpressure();
      clearLogs();
      base_addr = 10'd16; length = 11'd8; loop_en = 1'b0;
      for (int c = 0; c < 30; c++) begin
         start = (c == 0);
         src_ready = (c % 2 == 0);
         tick();
      end
      start = 1'b0;
      src_ready = 1'b1;
      checks++;
      if (outData.size() != 8 || csAddr.size() != 8) begin
         errors++;
         $display("[TB] FAIL bp_counts: got words=%0d reads=%0d, want 8 and 8",
                  outData.size(), csAddr.size());
      end
      for (int i = 0; i < 8 && i < outData.size(); i++) begin
         checks++;
         if (outData[i] !== 32'hA500_0010 + 32'(i) || outSop[i] !== (i == 0) ||
             outEop[i] !== (i == 7)) begin
            errors++;
            $display("[TB] FAIL bp_word%0d: got data=%h sop=%b eop=%b, want data=%h sop=%b eop=%b",
                     i, outData[i], outSop[i], outEop[i], 32'hA500_0010 + 32'(i), (i == 0), (i == 7));
         end
      end
      if (csCycle.size() == 8) begin
         checks++;
         if (csCycle[7] - csCycle[0] <= 7) begin
            errors++;
            $display("[TB] FAIL bp_throttle: got read span %0d cycles, want more than 7",
                     csCycle[7] - csCycle[0]);
         end
      end
      checks++;
      if (doneCycle.size() != 1) begin
         errors++;
         $display("[TB] FAIL bp_done: got %0d pulses, want 1", doneCycle.size());
      end
   endtask

   task automatic test_loop_stop();
      clearLogs();
      base_addr = 10'd100; length = 11'd3; loop_en = 1'b1; src_ready = 1'b1;
      for (int c = 0; c < 16; c++) begin
         start = (c == 0);
         stop  = (c == 8);
         tick();
      end
      start = 1'b0;
      stop = 1'b0;
      checks++;
      if (csAddr.size() != 7 || outData.size() != 7) begin
         errors++;
         $display("[TB] FAIL loop_counts: got reads=%0d words=%0d, want 7 and 7",
                  csAddr.size(), outData.size());
      end
      for (int i = 0; i < 7 && i < outData.size(); i++) begin
         checks++;
         if (outData[i] !== 32'hA500_0064 + 32'(i % 3) || outSop[i] !== (i % 3 == 0) ||
             outEop[i] !== (i % 3 == 2) || outCycle[i] != i + 3) begin
            errors++;
            $display("[TB] FAIL loop_word%0d: got data=%h sop=%b eop=%b cyc=%0d, want data=%h sop=%b eop=%b cyc=%0d",
                     i, outData[i], outSop[i], outEop[i], outCycle[i],
                     32'hA500_0064 + 32'(i % 3), (i % 3 == 0), (i % 3 == 2), i + 3);
         end
      end
      checks++;
      if (doneCycle.size() != 1 || doneCycle[0] != 10) begin
         errors++;
         $display("[TB] FAIL loop_done: got %0d pulses first cyc=%0d, want 1 pulse at cyc 10",
                  doneCycle.size(), (doneCycle.size() > 0) ? doneCycle[0] : -1);
      end
   endtask

   task automatic test_zero_length();
      clearLogs();
      base_addr = 10'd5; length = 11'd0; loop_en = 1'b0; src_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      checks++;
      if (csAddr.size() != 0 || busyCount != 0) begin
         errors++;
         $display("[TB] FAIL zero_len_idle: got reads=%0d busy_cycles=%0d, want 0 and 0",
                  csAddr.size(), busyCount);
      end
      checks++;
      if (doneCycle.size() != 1 || doneCycle[0] != 1) begin
         errors++;
         $display("[TB] FAIL zero_len_done: got %0d pulses first cyc=%0d, want 1 pulse at cyc 1",
                  doneCycle.size(), (doneCycle.size() > 0) ? doneCycle[0] : -1);
      end
   endtask

   task automatic test_midrun_reset();
      clearLogs();
      base_addr = 10'd0; length = 11'd8; loop_en = 1'b0; src_ready = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #1;
      checks++;
      if (src_valid !== 1'b1 || busy !== 1'b1 || csAddr.size() != 4) begin
         errors++;
         $display("[TB] FAIL midrun_prefill: got valid=%b busy=%b reads=%0d, want 1 1 4",
                  src_valid, busy, csAddr.size());
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, avm_address, avm_chipselect, avm_write, avm_byteenable, avm_clken,
           src_valid, src_data, src_sop, src_eop} !==
          {1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL midrun_reset_values: got busy=%b done=%b addr=%0d cs=%b valid=%b data=%h sop=%b eop=%b, want all 0",
                  busy, done, avm_address, avm_chipselect, src_valid, src_data, src_sop, src_eop);
      end
      @(negedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || doneCycle.size() != 0) begin
         errors++;
         $display("[TB] FAIL midrun_no_done: got done=%b logged=%0d, want 0 and 0",
                  done, doneCycle.size());
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_basic();
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_loop_stop();
      test_zero_length();
      test_midrun_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
